// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back controller: default queue
// depth, the hard-wired zero register index and the queued-write entry.
package wb_pkg;

  localparam int DEPTH_DEFAULT = 4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue: two write ports (port 0 is older than port 1), one
// read port at the head, and an age-ordered view of every slot
// (index 0 = oldest) so the controller can search for register matches.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0,
  input  wb_entry_t              din0,
  input  logic                   push1,
  input  wb_entry_t              din1,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output wb_entry_t              age_ent [DEPTH],
  output logic [DEPTH-1:0]       age_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt1;
  logic [CW-1:0] cnt_nxt;

  // Second write slot sits just behind the first; pointers wrap by width.
  always_comb begin
    wr_ptr_nxt1 = wr_ptr + AW'(1);
    cnt_nxt     = count + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Storage: no reset, slot validity comes from the count alone.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= din0;
    if (push1) mem[push0 ? wr_ptr_nxt1 : wr_ptr] <= din1;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= cnt_nxt;
    end
  end

  // Age-ordered view: slot k is the k-th oldest entry, valid when k < count.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_ent[k] = mem[rd_ptr + AW'(k)];
      age_vld[k] = (CW'(k) < count);
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: merges load results and ALU results into one
// register-file write port through a small pending-write queue, and reports
// pending (busy) destinations plus forwarded data for two read ports.
// Forwarding is enabled by defining WB_CTRL_BYPASS_EN; without it the
// forwarding outputs are tied to zero while busy tracking stays active.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Mem_valid,
  output logic        Mem_ready,
  input  logic [4:0]  Mem_rd,
  input  logic [31:0] Mem_d,
  input  logic        Alu_valid,
  output logic        Alu_ready,
  input  logic [4:0]  Alu_rd,
  input  logic [31:0] Alu_d,
  output logic [4:0]  Wr,
  output logic [31:0] D,
  output logic        We,
  input  logic [4:0]  Ra,
  input  logic [4:0]  Rb,
  output logic        Busy_a,
  output logic        Busy_b,
  output logic [31:0] Fwd_a,
  output logic [31:0] Fwd_b,
  output logic        Fwd_a_v,
  output logic        Fwd_b_v
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_FREE_C = CW'(DEPTH - 1);

`ifdef WB_CTRL_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [CW-1:0]    cnt_p0;
  wb_entry_t        age_ent_p0 [DEPTH];
  logic [DEPTH-1:0] age_vld_p0;
  logic             mem_acc_p0;
  logic             alu_acc_p0;
  logic             mem_push_p0;
  logic             alu_push_p0;
  logic             pop_p0;
  wb_entry_t        mem_ent_p0;
  wb_entry_t        alu_ent_p0;

  logic             vld_p1;
  logic [4:0]       wr_p1;
  logic [31:0]      d_p1;

  logic [31:0]      fwd_d_a;
  logic [31:0]      fwd_d_b;

  // A register is pending if any queued entry or the live write targets it.
  function automatic logic pending(input logic [4:0] r);
    logic hit;
    hit = vld_p1 && (wr_p1 == r);
    for (int k = 0; k < DEPTH; k++) begin
      if (age_vld_p0[k] && (age_ent_p0[k].rd == r)) hit = 1'b1;
    end
    return hit && (r != REG_ZERO);
  endfunction

  // Youngest matching data: later (younger) queue slots override older ones,
  // and every queue slot is younger than the write currently on the port.
  function automatic logic [31:0] youngest(input logic [4:0] r);
    logic [31:0] d;
    d = '0;
    if (vld_p1 && (wr_p1 == r)) d = d_p1;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_vld_p0[k] && (age_ent_p0[k].rd == r)) d = age_ent_p0[k].d;
    end
    if (r == REG_ZERO) d = '0;
    return d;
  endfunction

  // Stage p0: acceptance from the registered count, no same-cycle credit.
  // Mem is granted first; ALU only takes the last slot when Mem is idle.
  always_comb begin
    Mem_ready   = (cnt_p0 < FULL_C);
    Alu_ready   = (cnt_p0 < ONE_FREE_C) || ((cnt_p0 < FULL_C) && !Mem_valid);
    mem_acc_p0  = Mem_valid && Mem_ready;
    alu_acc_p0  = Alu_valid && Alu_ready;
    mem_push_p0 = mem_acc_p0 && (Mem_rd != REG_ZERO);
    alu_push_p0 = alu_acc_p0 && (Alu_rd != REG_ZERO);
    pop_p0      = (cnt_p0 != '0);
    mem_ent_p0  = '{rd: Mem_rd, d: Mem_d};
    alu_ent_p0  = '{rd: Alu_rd, d: Alu_d};
  end

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (Clk),
    .rst    (Clr),
    .push0  (mem_push_p0),
    .din0   (mem_ent_p0),
    .push1  (alu_push_p0),
    .din1   (alu_ent_p0),
    .pop    (pop_p0),
    .count  (cnt_p0),
    .age_ent(age_ent_p0),
    .age_vld(age_vld_p0)
  );

  // Stage p1: register-file write port, loaded from the queue head; the
  // address and data hold their last value while the queue is empty.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      vld_p1 <= 1'b0;
      wr_p1  <= '0;
      d_p1   <= '0;
    end else begin
      vld_p1 <= pop_p0;
      if (pop_p0) begin
        wr_p1 <= age_ent_p0[0].rd;
        d_p1  <= age_ent_p0[0].d;
      end
    end
  end

  assign We = vld_p1;
  assign Wr = wr_p1;
  assign D  = d_p1;

  // Hazard lookup for both read ports over the queue and the write port.
  always_comb begin
    Busy_a  = pending(Ra);
    Busy_b  = pending(Rb);
    fwd_d_a = youngest(Ra);
    fwd_d_b = youngest(Rb);
    Fwd_a_v = BYPASS_EN && Busy_a;
    Fwd_b_v = BYPASS_EN && Busy_b;
    Fwd_a   = BYPASS_EN ? fwd_d_a : 32'd0;
    Fwd_b   = BYPASS_EN ? fwd_d_b : 32'd0;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based reference model; a second
// two-entry instance exercises the completely-full condition.
`timescale 1ns/1ps
module tb_wb_ctrl;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Clr, Mem_valid, Alu_valid;
  logic [4:0]  Mem_rd, Alu_rd, Ra, Rb;
  logic [31:0] Mem_d, Alu_d;
  logic        Mem_ready, Alu_ready, We, Busy_a, Busy_b, Fwd_a_v, Fwd_b_v;
  logic [4:0]  Wr;
  logic [31:0] D, Fwd_a, Fwd_b;

  logic        s_clr, s_mv, s_av;
  logic [4:0]  s_mrd, s_ard, s_ra, s_rb;
  logic [31:0] s_md, s_ad;
  logic        s_mr, s_ar, s_we, s_busy_a, s_busy_b, s_fwd_av, s_fwd_bv;
  logic [4:0]  s_wr;
  logic [31:0] s_d, s_fwd_a, s_fwd_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we = 1'b0;
  logic [4:0]  m_wr = '0;
  logic [31:0] m_d  = '0;

  always #5 Clk = ~Clk;

  wb_ctrl #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Clr(Clr),
    .Mem_valid(Mem_valid), .Mem_ready(Mem_ready), .Mem_rd(Mem_rd), .Mem_d(Mem_d),
    .Alu_valid(Alu_valid), .Alu_ready(Alu_ready), .Alu_rd(Alu_rd), .Alu_d(Alu_d),
    .Wr(Wr), .D(D), .We(We), .Ra(Ra), .Rb(Rb),
    .Busy_a(Busy_a), .Busy_b(Busy_b), .Fwd_a(Fwd_a), .Fwd_b(Fwd_b),
    .Fwd_a_v(Fwd_a_v), .Fwd_b_v(Fwd_b_v)
  );

  wb_ctrl #(.DEPTH(2)) dut2 (
    .Clk(Clk), .Clr(s_clr),
    .Mem_valid(s_mv), .Mem_ready(s_mr), .Mem_rd(s_mrd), .Mem_d(s_md),
    .Alu_valid(s_av), .Alu_ready(s_ar), .Alu_rd(s_ard), .Alu_d(s_ad),
    .Wr(s_wr), .D(s_d), .We(s_we), .Ra(s_ra), .Rb(s_rb),
    .Busy_a(s_busy_a), .Busy_b(s_busy_b), .Fwd_a(s_fwd_a), .Fwd_b(s_fwd_b),
    .Fwd_a_v(s_fwd_av), .Fwd_b_v(s_fwd_bv)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: a register is busy if it is waiting in the queue or being written now.
  function automatic logic exp_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (m_we && (m_wr == r)) return 1'b1;
    foreach (q[i]) if (q[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: newest queued value wins, then the value on the write port.
  function automatic logic [31:0] exp_fwd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].rd == r) return q[i].d;
    if (m_we && (m_wr == r)) return m_d;
    return 32'd0;
  endfunction

  task automatic check_all();
    int   cnt;
    logic emr, ear;
    cnt = q.size();
    emr = (cnt < DEPTH);
    ear = (cnt < DEPTH - 1) || ((cnt < DEPTH) && !Mem_valid);
    check("We",        32'(We),        32'(m_we));
    check("Wr",        32'(Wr),        32'(m_wr));
    check("D",         D,              m_d);
    check("Mem_ready", 32'(Mem_ready), 32'(emr));
    check("Alu_ready", 32'(Alu_ready), 32'(ear));
    check("Busy_a",    32'(Busy_a),    32'(exp_busy(Ra)));
    check("Busy_b",    32'(Busy_b),    32'(exp_busy(Rb)));
`ifdef WB_CTRL_BYPASS_EN
    check("Fwd_a_v",   32'(Fwd_a_v),   32'(exp_busy(Ra)));
    check("Fwd_b_v",   32'(Fwd_b_v),   32'(exp_busy(Rb)));
    check("Fwd_a",     Fwd_a,          exp_fwd(Ra));
    check("Fwd_b",     Fwd_b,          exp_fwd(Rb));
`else
    check("Fwd_a_v",   32'(Fwd_a_v),   32'd0);
    check("Fwd_b_v",   32'(Fwd_b_v),   32'd0);
    check("Fwd_a",     Fwd_a,          32'd0);
    check("Fwd_b",     Fwd_b,          32'd0);
`endif
  endtask

  // Reference update at a rising edge, from the inputs applied in the cycle.
  task automatic model_edge();
    int   cnt;
    logic ma, aa;
    ent_t e;
    if (Clr) begin
      q.delete();
      m_we = 1'b0;
      m_wr = '0;
      m_d  = '0;
    end else begin
      cnt = q.size();
      ma  = Mem_valid && (cnt < DEPTH);
      aa  = Alu_valid && ((cnt < DEPTH - 1) || ((cnt < DEPTH) && !Mem_valid));
      if (cnt > 0) begin
        e    = q.pop_front();
        m_we = 1'b1;
        m_wr = e.rd;
        m_d  = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (ma && (Mem_rd != 5'd0)) q.push_back('{rd: Mem_rd, d: Mem_d});
      if (aa && (Alu_rd != 5'd0)) q.push_back('{rd: Alu_rd, d: Alu_d});
    end
  endtask

  // One cycle: drive at the falling edge, check, clock, update the model.
  task automatic step(input logic clr, input logic mv, input logic [4:0] mrd,
                      input logic [31:0] md, input logic av, input logic [4:0] ard,
                      input logic [31:0] ad, input logic [4:0] ra, input logic [4:0] rb);
    Clr = clr; Mem_valid = mv; Mem_rd = mrd; Mem_d = md;
    Alu_valid = av; Alu_rd = ard; Alu_d = ad; Ra = ra; Rb = rb;
    #1;
    if (chk_en) check_all();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic s_tick();
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  initial begin
    logic [31:0] fwd_exp;
    Clr = 1'b1; Mem_valid = 1'b0; Alu_valid = 1'b0; Mem_rd = '0; Alu_rd = '0;
    Mem_d = '0; Alu_d = '0; Ra = '0; Rb = '0;
    s_clr = 1'b1; s_mv = 1'b0; s_av = 1'b0; s_mrd = '0; s_ard = '0;
    s_md = '0; s_ad = '0; s_ra = '0; s_rb = '0;
    @(negedge Clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset state
    check("rst_We",  32'(We), 0);
    check("rst_Wr",  32'(Wr), 0);
    check("rst_D",   D, 0);
    check("rst_mr",  32'(Mem_ready), 1);
    check("rst_ar",  32'(Alu_ready), 1);
    check("rst_bsy", 32'(Busy_a), 0);

    // Basic write: rd=5 from Mem, visible on the port two cycles later
    step(0, 1, 5, 32'h1234, 0, 0, 0, 5, 0);
    check("bw_busy_q", 32'(Busy_a), 1);
    check("bw_we0",    32'(We), 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 0);
    check("bw_we",     32'(We), 1);
    check("bw_wr",     32'(Wr), 5);
    check("bw_d",      D, 32'h1234);
    check("bw_busy_w", 32'(Busy_a), 1);
    step(0, 0, 0, 0, 0, 0, 0, 5, 0);
    check("bw_we_off", 32'(We), 0);
    check("bw_busy0",  32'(Busy_a), 0);

    // Dual issue to the same register: Mem older, ALU younger
`ifdef WB_CTRL_BYPASS_EN
    fwd_exp = 32'hB;
`else
    fwd_exp = 32'h0;
`endif
    step(0, 1, 3, 32'hA, 1, 3, 32'hB, 3, 0);
    check("di_busy", 32'(Busy_a), 1);
    check("di_fwd1", Fwd_a, fwd_exp);
    step(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("di_d1",   D, 32'hA);
    check("di_wr1",  32'(Wr), 3);
    check("di_fwd2", Fwd_a, fwd_exp);
    step(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("di_d2",   D, 32'hB);
    check("di_we2",  32'(We), 1);
    step(0, 0, 0, 0, 0, 0, 0, 3, 0);
    check("di_we_off", 32'(We), 0);

    // Zero-register write is accepted but never reaches the port
    step(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    check("z_we1",   32'(We), 0);
    check("z_busy",  32'(Busy_a), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("z_we2",   32'(We), 0);

    // Fill to three entries; with one slot left and both valid only Mem wins
    step(0, 1, 1, 32'h11, 1, 2, 32'h22, 1, 2);
    step(0, 1, 3, 32'h33, 1, 4, 32'h44, 1, 2);
    check("f_mr3",   32'(Mem_ready), 1);
    check("f_ar3",   32'(Alu_ready), 0);
    step(0, 1, 5, 32'h55, 1, 6, 32'h66, 5, 6);
    check("f_wr",    32'(Wr), 2);
    check("f_alu_dropped", 32'(Busy_b), 0);
    check("f_mem_taken",   32'(Busy_a), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 5, 6);

    // Reset with three queued entries
    step(0, 1, 7, 32'h77, 1, 8, 32'h88, 7, 8);
    step(0, 1, 9, 32'h99, 1, 10, 32'hAA, 7, 8);
    step(1, 0, 0, 0, 0, 0, 0, 9, 10);
    check("mr_we",   32'(We), 0);
    check("mr_mr",   32'(Mem_ready), 1);
    check("mr_ar",   32'(Alu_ready), 1);
    check("mr_busy", 32'(Busy_a), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 9, 10);
      check("mr_no_stale", 32'(We), 0);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Two-entry instance: completely full, ready held low during the pop
    s_tick();
    s_clr = 1'b0;
    s_mv = 1; s_mrd = 1; s_md = 32'h11; s_av = 1; s_ard = 2; s_ad = 32'h22;
    #1;
    check("d2_mr_empty", 32'(s_mr), 1);
    check("d2_ar_empty", 32'(s_ar), 1);
    s_tick();
    s_mrd = 3; s_md = 32'h33; s_ard = 4; s_ad = 32'h44;
    #1;
    check("d2_mr_full", 32'(s_mr), 0);
    check("d2_ar_full", 32'(s_ar), 0);
    check("d2_we_full", 32'(s_we), 0);
    s_tick();
    check("d2_we1", 32'(s_we), 1);
    check("d2_wr1", 32'(s_wr), 1);
    check("d2_d1",  s_d, 32'h11);
    check("d2_mr1", 32'(s_mr), 1);
    check("d2_ar1", 32'(s_ar), 0);
    s_tick();
    s_mv = 0; s_av = 0;
    #1;
    check("d2_wr2", 32'(s_wr), 2);
    check("d2_d2",  s_d, 32'h22);
    check("d2_ar2", 32'(s_ar), 1);
    s_tick();
    check("d2_we3", 32'(s_we), 1);
    check("d2_wr3", 32'(s_wr), 3);
    check("d2_d3",  s_d, 32'h33);
    s_tick();
    check("d2_we_idle", 32'(s_we), 0);
    check("d2_wr_hold", 32'(s_wr), 3);
    check("d2_d_hold",  s_d, 32'h33);
    check("d2_busy_r0", 32'(s_busy_a | s_busy_b), 0);
    check("d2_fwdv_r0", 32'(s_fwd_av | s_fwd_bv), 0);
    check("d2_fwd_r0",  s_fwd_a | s_fwd_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
